// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Captures enabled rising edges on N_CH level inputs into per-channel pending
// flags and offers them one at a time to a consumer.
// Channels are chosen round-robin, and the consumer accepts with a
// valid/ready handshake.
// An edge that arrives while its channel is still pending is dropped.
// A drop is reported with a one-cycle overflow pulse on that channel.

module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_edge,
    input  logic [N_CH-1:0] ch_en,
    input  logic            ev_ready,
    output logic            ev_valid,
    output logic [ID_W-1:0] ev_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow
);

    // One-hot style encoding so that the two unused codes can be detected
    // and recovered from.
    localparam logic [1:0] S_IDLE  = 2'b01;
    localparam logic [1:0] S_OFFER = 2'b10;

    logic [1:0]      r_state;
    logic [N_CH-1:0] r_prev;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_overflow;
    logic [ID_W-1:0] r_ev_id;
    logic [ID_W-1:0] r_last_grant;

    logic [N_CH-1:0] w_rise;
    logic            w_accept;
    logic [N_CH-1:0] w_clear;
    logic            w_found;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_idx;

    assign ev_valid = (r_state == S_OFFER);
    assign ev_id    = r_ev_id;
    assign pending  = r_pending;
    assign overflow = r_overflow;

    assign w_rise   = in_edge & ~r_prev & ch_en;
    assign w_accept = ev_valid & ev_ready;
    assign w_clear  = {N_CH{w_accept}} & (N_CH'(1) << r_ev_id);

    // Round-robin search: the first pending channel after the last grant wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % N_CH);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Previous-level history, updated every cycle whether or not the channel is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= in_edge;
        end
    end

    // Pending flags and overflow pulses: a rise that lands on an accept survives, otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            r_overflow <= w_rise & r_pending & ~w_clear;
        end
    end

    // Controller: pick a channel in IDLE, hold it in OFFER until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ev_id      <= '0;
            r_last_grant <= ID_W'(N_CH - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ev_id <= w_sel;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (ev_ready) begin
                        r_last_grant <= r_ev_id;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
